// File: rtl/sigma_irq_ctrl.sv
// Tile interrupt controller: merges timer, SGI and synchronised external IRQs into a
// pending register and hands the lowest enabled one to the core via req/ack/eoi.
module sigma_irq_ctrl #(
  parameter int unsigned IRQ_NUM_POW     = 4,
  parameter int unsigned TIMER_IRQ_NUM   = 0,
  parameter int unsigned EXT_SYNC_STAGES = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [(1<<IRQ_NUM_POW)-1:0]     irq_en_bi,
  input  logic                            irq_timer_i,
  input  logic                            sgi_req_i,
  input  logic [IRQ_NUM_POW-1:0]          sgi_code_bi,
  input  logic [(1<<IRQ_NUM_POW)-1:0]     ext_irq_bi,
  output logic                            core_irq_req_o,
  output logic [IRQ_NUM_POW-1:0]          core_irq_code_bo,
  input  logic                            core_irq_ack_i,
  input  logic                            core_irq_eoi_i,
  output logic [(1<<IRQ_NUM_POW)-1:0]     pending_bo
);

  localparam int unsigned N = 1 << IRQ_NUM_POW;
  localparam logic [IRQ_NUM_POW-1:0] TIMER_IDX = IRQ_NUM_POW'(TIMER_IRQ_NUM);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  logic [EXT_SYNC_STAGES-1:0][N-1:0] sync_q;
  logic [N-1:0]                      ext_last_q;
  logic [N-1:0]                      ext_rise;
  logic [N-1:0]                      set_vec;
  logic [N-1:0]                      clr_vec;
  logic [N-1:0]                      eligible;
  logic [N-1:0]                      pending_q, pending_d;
  logic [1:0]                        state_q, state_d;
  logic [IRQ_NUM_POW-1:0]            code_q, code_d;
  logic [IRQ_NUM_POW-1:0]            low_idx;

  // ext_last_q holds the previous synchronised level so a held line sets pending once
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync_q     <= '0;
      ext_last_q <= '0;
    end else begin
      sync_q     <= {sync_q[EXT_SYNC_STAGES-2:0], ext_irq_bi};
      ext_last_q <= sync_q[EXT_SYNC_STAGES-1];
    end
  end

  assign ext_rise = sync_q[EXT_SYNC_STAGES-1] & ~ext_last_q;

  always_comb begin
    set_vec = ext_rise;
    if (irq_timer_i) set_vec[TIMER_IDX]   = 1'b1;
    if (sgi_req_i)   set_vec[sgi_code_bi] = 1'b1;
  end

  assign eligible = pending_q & irq_en_bi;

  always_comb begin
    low_idx = '0;
    for (int unsigned i = N; i > 0; i--) begin
      if (eligible[i-1]) low_idx = IRQ_NUM_POW'(i - 1);
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    clr_vec = '0;
    case (state_q)
      ST_IDLE: begin
        if (|eligible) begin
          state_d = ST_REQ;
          code_d  = low_idx;
        end
      end
      ST_REQ: begin
        if (core_irq_ack_i) begin
          clr_vec[code_q] = 1'b1;
          state_d         = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (core_irq_eoi_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // new sets are applied after the ack-clear so a same-cycle set keeps the bit pending
  assign pending_d = (pending_q & ~clr_vec) | set_vec;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pending_q <= '0;
      state_q   <= ST_IDLE;
      code_q    <= '0;
    end else begin
      pending_q <= pending_d;
      state_q   <= state_d;
      code_q    <= code_d;
    end
  end

  assign core_irq_req_o   = (state_q == ST_REQ);
  assign core_irq_code_bo = code_q;
  assign pending_bo       = pending_q;

endmodule

// File: tb/tb_sigma_irq_ctrl.sv
// Randomised and directed bench for sigma_irq_ctrl against a behavioural model.
module tb_sigma_irq_ctrl;

  localparam int unsigned POW  = 4;
  localparam int unsigned N    = 16;
  localparam int unsigned TNUM = 0;
  localparam int unsigned S    = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   en = '0;
  logic           timer = 1'b0;
  logic           sgi = 1'b0;
  logic [POW-1:0] sgi_code = '0;
  logic [N-1:0]   ext = '0;
  logic           ack = 1'b0;
  logic           eoi = 1'b0;
  logic           req;
  logic [POW-1:0] code;
  logic [N-1:0]   pend;

  int vectors = 0;
  int miscompares = 0;

  // model: pending set, whether a request is outstanding / being serviced, latched code,
  // and the recent history of sampled external levels (index 0 = newest sample)
  logic [N-1:0]   m_pend;
  bit             m_requesting;
  bit             m_servicing;
  logic [POW-1:0] m_code;
  logic [N-1:0]   m_hist [S+2];

  sigma_irq_ctrl #(
    .IRQ_NUM_POW    (POW),
    .TIMER_IRQ_NUM  (TNUM),
    .EXT_SYNC_STAGES(S)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_n),
    .irq_en_bi       (en),
    .irq_timer_i     (timer),
    .sgi_req_i       (sgi),
    .sgi_code_bi     (sgi_code),
    .ext_irq_bi      (ext),
    .core_irq_req_o  (req),
    .core_irq_code_bo(code),
    .core_irq_ack_i  (ack),
    .core_irq_eoi_i  (eoi),
    .pending_bo      (pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < int'(N); i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_pend       = '0;
    m_requesting = 1'b0;
    m_servicing  = 1'b0;
    m_code       = '0;
    for (int k = 0; k < int'(S) + 2; k++) m_hist[k] = '0;
  endtask

  // one clock edge of the specified behaviour, using the inputs present at that edge
  task automatic model_edge();
    logic [N-1:0] sets;
    logic [N-1:0] elig;
    for (int k = int'(S) + 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = ext;
    sets = m_hist[S] & ~m_hist[S+1];
    if (timer) sets[TNUM] = 1'b1;
    if (sgi)   sets[sgi_code] = 1'b1;
    elig = m_pend & en;
    if (m_requesting) begin
      if (ack) begin
        m_pend[m_code] = 1'b0;
        m_requesting   = 1'b0;
        m_servicing    = 1'b1;
      end
    end else if (m_servicing) begin
      if (eoi) m_servicing = 1'b0;
    end else if (elig != '0) begin
      m_requesting = 1'b1;
      m_code       = POW'(lowest(elig));
    end
    m_pend = m_pend | sets;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req_drop", 32'(req), 32'd0);
    chk("rst_pend_clear", 32'(pend), 32'd0);
    model_reset();
    tick();
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    chk("model_req", 32'(req), 32'(m_requesting));
    if (m_requesting) chk("model_code", 32'(code), 32'(m_code));
    chk("model_pending", 32'(pend), 32'(m_pend));
  end

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_req", 32'(req), 32'd0);
    chk("reset_code", 32'(code), 32'd0);
    chk("reset_pend", 32'(pend), 32'd0);
    rst_n = 1'b1;

    // timer line 0 -> request one edge after the pulse
    en = 16'h0001; timer = 1'b1; tick(); timer = 1'b0;
    chk("t1_pend_set", 32'(pend), 32'h0001);
    chk("t1_no_req_yet", 32'(req), 32'd0);
    tick();
    chk("t1_req", 32'(req), 32'd1);
    chk("t1_code", 32'(code), 32'd0);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t1_req_drop", 32'(req), 32'd0);
    chk("t1_pend_clr", 32'(pend), 32'h0000);
    eoi = 1'b1; tick(); eoi = 1'b0;

    // SGI 5 then SGI 3 land while a handler runs -> 3 served first, then 5
    en = 16'hFFFF; timer = 1'b1; tick(); timer = 1'b0; tick();
    ack = 1'b1; tick(); ack = 1'b0;
    sgi = 1'b1; sgi_code = 4'd5; tick(); sgi_code = 4'd3; tick(); sgi = 1'b0;
    chk("t2_pend_both", 32'(pend), 32'h0028);
    chk("t2_no_req_active", 32'(req), 32'd0);
    eoi = 1'b1; tick(); eoi = 1'b0;
    chk("t2_req_not_at_eoi", 32'(req), 32'd0);
    tick();
    chk("t2_first_req", 32'(req), 32'd1);
    chk("t2_first_code", 32'(code), 32'd3);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t2_pend_left", 32'(pend), 32'h0020);
    eoi = 1'b1; tick(); eoi = 1'b0; tick();
    chk("t2_second_req", 32'(req), 32'd1);
    chk("t2_second_code", 32'(code), 32'd5);
    ack = 1'b1; tick(); ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;

    // disabled pending bit becomes eligible on enable
    en = 16'h0000; sgi = 1'b1; sgi_code = 4'd7; tick(); sgi = 1'b0; tick();
    chk("t3_pend_masked", 32'(pend), 32'h0080);
    chk("t3_no_req", 32'(req), 32'd0);
    en = 16'h0080; tick();
    chk("t3_req", 32'(req), 32'd1);
    chk("t3_code", 32'(code), 32'd7);
    ack = 1'b1; tick(); ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;

    // held external level sets pending exactly once; a new rising edge sets it again
    en = 16'h0000; ext = 16'h0004;
    tick(); chk("t4_lat_e0", 32'(pend), 32'h0000);
    tick(); chk("t4_lat_e1", 32'(pend), 32'h0000);
    tick(); chk("t4_lat_e2", 32'(pend), 32'h0004);
    en = 16'h0004; tick();
    chk("t4_req", 32'(req), 32'd1);
    chk("t4_code", 32'(code), 32'd2);
    ack = 1'b1; tick(); ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
    repeat (16) tick();
    chk("t4_held_no_reset", 32'(pend), 32'h0000);
    chk("t4_held_no_req", 32'(req), 32'd0);
    ext = 16'h0000; repeat (4) tick();
    ext = 16'h0004; tick(); tick();
    chk("t4_second_lat", 32'(pend), 32'h0000);
    tick();
    chk("t4_second_set", 32'(pend), 32'h0004);
    ext = 16'h0000; tick();
    ack = 1'b1; tick(); ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;

    // request held through disable; same-cycle set beats ack-clear
    en = 16'hFFFF; sgi = 1'b1; sgi_code = 4'd4; tick(); sgi = 1'b0; tick();
    chk("t5_req", 32'(req), 32'd1);
    chk("t5_code", 32'(code), 32'd4);
    en = 16'hFFEF; tick();
    chk("t5_req_held", 32'(req), 32'd1);
    chk("t5_code_held", 32'(code), 32'd4);
    tick();
    chk("t5_req_held2", 32'(req), 32'd1);
    ack = 1'b1; sgi = 1'b1; sgi_code = 4'd4; tick(); ack = 1'b0; sgi = 1'b0;
    chk("t5_req_drop", 32'(req), 32'd0);
    chk("t5_set_wins", 32'(pend), 32'h0010);
    eoi = 1'b1; tick(); eoi = 1'b0; tick();
    chk("t5_masked_no_req", 32'(req), 32'd0);
    en = 16'hFFFF; tick();
    chk("t5_reenabled_req", 32'(req), 32'd1);
    ack = 1'b1; tick(); ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;

    // asynchronous reset in REQ and in ACTIVE
    sgi = 1'b1; sgi_code = 4'd9; tick(); sgi_code = 4'd11; tick(); sgi = 1'b0;
    chk("t6_req", 32'(req), 32'd1);
    chk("t6_pend", 32'(pend), 32'h0A00);
    async_reset();
    repeat (3) tick();
    chk("t6_no_replay_req", 32'(req), 32'd0);
    chk("t6_no_replay_pend", 32'(pend), 32'h0000);
    sgi = 1'b1; sgi_code = 4'd6; tick(); sgi = 1'b0; tick();
    ack = 1'b1; tick(); ack = 1'b0;
    sgi = 1'b1; sgi_code = 4'd1; tick(); sgi = 1'b0;
    chk("t6_active_pend", 32'(pend), 32'h0002);
    async_reset();
    sgi = 1'b1; sgi_code = 4'd12; tick(); sgi = 1'b0; tick();
    chk("t6_idle_after_rst", 32'(req), 32'd1);
    chk("t6_code_after_rst", 32'(code), 32'd12);
    ack = 1'b1; tick(); ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 49) == 0)
        en = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      timer    = ($urandom_range(0, 15) == 0);
      sgi      = ($urandom_range(0, 7) == 0);
      sgi_code = 4'($urandom);
      if ($urandom_range(0, 15) == 0) ext[$urandom_range(0, 15)] ^= 1'b1;
      ack      = ($urandom_range(0, 2) == 0);
      eoi      = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 599) == 0) async_reset();
      else tick();
    end
    timer = 1'b0; sgi = 1'b0; ack = 1'b0; eoi = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
